activation: RTL

- Parametrised successor to the single-mode step activation. Elementwise nonlinearity between a neuron's weighted-sum output and the next layer.
- Forward path: signed ARG_WIDTH argument in, unsigned RES_WIDTH activation out. MODE selects step or saturating rectifier.
- Training path: each forward's derivative bit is kept in a DEPTH-entry history FIFO, so up to DEPTH forwards can be in flight before their matching backward passes.
- All four streams use valid/ready handshakes.

---
 rtl/activation.sv | 136 +++++++++++++
 1 files changed

// File: rtl/activation.sv
// Elementwise activation with step / saturating-rectifier forward path and a
// derivative history FIFO that gates back-propagated errors.
module activation #(
   parameter int ARG_WIDTH = 16,
   parameter int RES_WIDTH = 8,
   parameter int ERR_WIDTH = 16,
   parameter int DEPTH     = 4,
   parameter int MODE      = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 train,
   input  logic                 argument_valid,
   input  logic [ARG_WIDTH-1:0] argument_data,
   output logic                 argument_ready,
   output logic                 result_valid,
   output logic [RES_WIDTH-1:0] result_data,
   input  logic                 result_ready,
   input  logic                 error_valid,
   input  logic [ERR_WIDTH-1:0] error_data,
   output logic                 error_ready,
   output logic                 propagate_valid,
   output logic [ERR_WIDTH-1:0] propagate_data,
   input  logic                 propagate_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic signed [ARG_WIDTH-1:0] LIMIT =
      {{(ARG_WIDTH-RES_WIDTH){1'b0}}, {RES_WIDTH{1'b1}}};

   logic signed [ARG_WIDTH-1:0] arg;
   logic                        arg_neg;
   logic                        arg_pos;
   logic [RES_WIDTH-1:0]        act;
   logic                        deriv;

   logic [DEPTH-1:0] hist;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             arg_fire;
   logic             err_fire;
   logic             push;
   logic             pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign arg     = argument_data;
   assign arg_neg = arg[ARG_WIDTH-1];
   assign arg_pos = !arg_neg && (|arg);

   always_comb begin
      act   = '0;
      deriv = 1'b1;
      if (MODE == 0) begin
         act   = arg_neg ? '0 : '1;
         deriv = 1'b1;
      end else begin
         deriv = arg_pos;
         if (!arg_pos)
            act = '0;
         else if (arg > LIMIT)
            act = '1;
         else
            act = arg[RES_WIDTH-1:0];
      end
   end

   assign full  = (count == FULL);
   assign empty = (count == '0);

   // Readies fall with reset itself so nothing is accepted while it is held.
   assign argument_ready = !reset
                         && (!result_valid || result_ready)
                         && !(train && full);
   assign error_ready    = !reset && !empty
                         && (!propagate_valid || propagate_ready);

   assign arg_fire = argument_valid && argument_ready;
   assign err_fire = error_valid && error_ready;
   assign push     = arg_fire && train;
   assign pop      = err_fire;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_valid <= 1'b0;
         result_data  <= '0;
      end else if (arg_fire) begin
         result_valid <= 1'b1;
         result_data  <= act;
      end else if (result_ready) begin
         result_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         propagate_valid <= 1'b0;
         propagate_data  <= '0;
      end else if (err_fire) begin
         propagate_valid <= 1'b1;
         propagate_data  <= hist[rd_ptr] ? error_data : '0;
      end else if (propagate_ready) begin
         propagate_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hist   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            hist[wr_ptr] <= deriv;
            wr_ptr       <= bump(wr_ptr);
         end
         if (pop)
            rd_ptr <= bump(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
